// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with a req/ready memory handshake, a bus-timeout
// watchdog, illegal-opcode trapping, AUIPC and a two-step JALR link sequence.
// Optional feature macro: MULTICYCLE_PERF_CNT_EN adds cycle / retired-instruction
// counters; when it is undefined, perf_cycles and perf_instret are tied to zero.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             addr_src,
    output logic             instr_flop_wen,
    output logic             pc_wen,
    output logic             reg_write,
    output logic [2:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_a_src,
    output logic [1:0]       alu_b_src,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_instret
);

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_EXEC_B, S_EXEC_J, S_EXEC_JR,
        S_JR_LINK, S_IMM_WB, S_TRAP
    } state_t;

    // Immediate format selected purely from the opcode.
    function automatic logic [2:0] imm_decode(input logic [6:0] op);
        case (op)
            OP_LW, OP_JALR, OP_IMM: imm_decode = 3'd0;
            OP_SW:                  imm_decode = 3'd1;
            OP_BRANCH:              imm_decode = 3'd2;
            OP_LUI, OP_AUIPC:       imm_decode = 3'd3;
            OP_JAL:                 imm_decode = 3'd4;
            default:                imm_decode = 3'd0;
        endcase
    endfunction

    // Branch decision: equality class uses alu_zero, compare class uses the
    // SLT/SLTU result (alu_zero low means "less than"); funct3 010/011 never branch.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        if (f3[2] == 1'b0) begin
            branch_taken = f3[1] ? 1'b0 : (zero ^ f3[0]);
        end else begin
            branch_taken = (~zero) ^ f3[0];
        end
    endfunction

    state_t           state_r, state_nxt_s;
    logic [TMO_W-1:0] wait_cnt_r;
    logic             fault_r;
    logic [1:0]       cause_r;
    logic [1:0]       trap_cause_s;
    logic             timeout_s;

    logic       mem_req_s, mem_write_s, addr_src_s, ifw_s, pc_wen_s, reg_write_s;
    logic [2:0] alu_op_s;
    logic [1:0] result_src_s, a_src_s, b_src_s;

    assign timeout_s = (TIMEOUT_CYCLES != 0) && !mem_ready &&
                       (wait_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt_s  = state_r;
        trap_cause_s = 2'd0;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        addr_src_s   = 1'b0;
        ifw_s        = 1'b0;
        pc_wen_s     = 1'b0;
        reg_write_s  = 1'b0;
        alu_op_s     = 3'd0;
        result_src_s = 2'd0;
        a_src_s      = 2'd0;
        b_src_s      = 2'd0;
        case (state_r)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                b_src_s      = 2'd2;
                result_src_s = 2'd2;
                if (mem_ready) begin
                    ifw_s       = 1'b1;
                    pc_wen_s    = 1'b1;
                    state_nxt_s = S_DECODE;
                end else if (timeout_s) begin
                    state_nxt_s  = S_TRAP;
                    trap_cause_s = 2'd2;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                a_src_s = 2'd1;
                b_src_s = 2'd1;
                case (opcode)
                    OP_R:                        state_nxt_s = S_EXEC_R;
                    OP_IMM:                      state_nxt_s = S_EXEC_I;
                    OP_BRANCH:                   state_nxt_s = S_EXEC_B;
                    OP_JAL:                      state_nxt_s = S_EXEC_J;
                    OP_LW, OP_SW, OP_JALR, OP_LUI: state_nxt_s = S_MEM_ADDR;
                    OP_AUIPC:                    state_nxt_s = S_ALU_WB;
                    default: begin
                        state_nxt_s  = S_TRAP;
                        trap_cause_s = 2'd1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                a_src_s = 2'd2;
                b_src_s = 2'd1;
                case (opcode)
                    OP_LW:   state_nxt_s = S_MEM_READ;
                    OP_SW:   state_nxt_s = S_MEM_WRITE;
                    OP_JALR: state_nxt_s = S_EXEC_JR;
                    OP_LUI:  state_nxt_s = S_IMM_WB;
                    default: begin
                        state_nxt_s  = S_TRAP;
                        trap_cause_s = 2'd1;
                    end
                endcase
            end
            S_MEM_READ, S_MEM_WRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = (state_r == S_MEM_WRITE);
                addr_src_s  = 1'b1;
                if (mem_ready) begin
                    state_nxt_s = (state_r == S_MEM_READ) ? S_MEM_WB : S_FETCH;
                end else if (timeout_s) begin
                    state_nxt_s  = S_TRAP;
                    trap_cause_s = 2'd2;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_MEM_WB: begin
                result_src_s = 2'd1;
                reg_write_s  = 1'b1;
                state_nxt_s  = S_FETCH;
            end
            S_EXEC_R: begin
                a_src_s     = 2'd2;
                alu_op_s    = 3'd2;
                state_nxt_s = S_ALU_WB;
            end
            S_EXEC_I: begin
                a_src_s     = 2'd2;
                b_src_s     = 2'd1;
                alu_op_s    = 3'd2;
                state_nxt_s = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_EXEC_B: begin
                a_src_s     = 2'd2;
                alu_op_s    = 3'd3;
                pc_wen_s    = branch_taken(funct3, alu_zero);
                state_nxt_s = S_FETCH;
            end
            S_EXEC_J: begin
                a_src_s     = 2'd1;
                b_src_s     = 2'd2;
                pc_wen_s    = 1'b1;
                state_nxt_s = S_ALU_WB;
            end
            S_EXEC_JR: begin
                a_src_s      = 2'd2;
                b_src_s      = 2'd1;
                result_src_s = 2'd2;
                pc_wen_s     = 1'b1;
                state_nxt_s  = S_JR_LINK;
            end
            S_JR_LINK: begin
                a_src_s     = 2'd1;
                b_src_s     = 2'd2;
                state_nxt_s = S_ALU_WB;
            end
            S_IMM_WB: begin
                result_src_s = 2'd3;
                reg_write_s  = 1'b1;
                state_nxt_s  = S_FETCH;
            end
            S_TRAP: begin
                state_nxt_s = S_TRAP;
            end
            default: begin
                state_nxt_s  = S_TRAP;
                trap_cause_s = 2'd1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait counter: counts stalled request cycles, cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {TMO_W{1'b0}};
        end else if (mem_req_s && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + TMO_W'(1);
        end else begin
            wait_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // Sticky fault flag and cause, captured on entry to TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
            cause_r <= 2'd0;
        end else if ((state_nxt_s == S_TRAP) && (state_r != S_TRAP)) begin
            fault_r <= 1'b1;
            cause_r <= trap_cause_s;
        end else begin
            fault_r <= fault_r;
            cause_r <= cause_r;
        end
    end

    // Outputs are forced to zero for as long as reset is held.
    assign mem_req        = rst_n & mem_req_s;
    assign mem_write      = rst_n & mem_write_s;
    assign addr_src       = rst_n & addr_src_s;
    assign instr_flop_wen = rst_n & ifw_s;
    assign pc_wen         = rst_n & pc_wen_s;
    assign reg_write      = rst_n & reg_write_s;
    assign alu_op         = rst_n ? alu_op_s     : 3'd0;
    assign imm_sel        = rst_n ? imm_decode(opcode) : 3'd0;
    assign result_src     = rst_n ? result_src_s : 2'd0;
    assign alu_a_src      = rst_n ? a_src_s      : 2'd0;
    assign alu_b_src      = rst_n ? b_src_s      : 2'd0;
    assign fault          = fault_r;
    assign fault_cause    = cause_r;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic             retire_s;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [CNT_W-1:0] ret_cnt_r;

    // Retire strobe: writeback states, branch resolve, or a completed store.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            S_ALU_WB, S_MEM_WB, S_IMM_WB, S_EXEC_B: retire_s = 1'b1;
            S_MEM_WRITE:                            retire_s = mem_ready;
            default:                                retire_s = 1'b0;
        endcase
    end

    // Performance counters, frozen while trapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_r <= {CNT_W{1'b0}};
            ret_cnt_r <= {CNT_W{1'b0}};
        end else begin
            cyc_cnt_r <= (state_r != S_TRAP) ? cyc_cnt_r + CNT_W'(1) : cyc_cnt_r;
            ret_cnt_r <= retire_s ? ret_cnt_r + CNT_W'(1) : ret_cnt_r;
        end
    end

    assign perf_cycles  = cyc_cnt_r;
    assign perf_instret = ret_cnt_r;
`else
    assign perf_cycles  = {CNT_W{1'b0}};
    assign perf_instret = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into a queue of
// expected per-cycle control vectors from the instruction's semantics, then
// replayed against the DUT with randomised wait states and branch conditions.
module tb_multicycle_controller;

    localparam logic [6:0] T_LW = 7'b0000011, T_IMM = 7'b0010011, T_AUIPC = 7'b0010111;
    localparam logic [6:0] T_SW = 7'b0100011, T_R = 7'b0110011, T_LUI = 7'b0110111;
    localparam logic [6:0] T_BR = 7'b1100011, T_JALR = 7'b1100111, T_JAL = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alu_zero, mem_ready;
    logic        mem_req, mem_write, addr_src, instr_flop_wen, pc_wen, reg_write;
    logic [2:0]  alu_op, imm_sel;
    logic [1:0]  result_src, alu_a_src, alu_b_src, fault_cause;
    logic        fault;
    logic [31:0] perf_cycles, perf_instret;

    int total = 0;
    int bad   = 0;
    int m_cycles  = 0;
    int m_instret = 0;

    typedef struct packed {
        logic       rdy;
        logic       req, wr, as_, ifw, pcw, rw;
        logic [2:0] aop;
        logic [1:0] rs, a, b;
    } cyc_t;

    cyc_t q[$];

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT_CYCLES(4), .TMO_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .addr_src(addr_src), .instr_flop_wen(instr_flop_wen),
        .pc_wen(pc_wen), .reg_write(reg_write), .alu_op(alu_op), .imm_sel(imm_sel),
        .result_src(result_src), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
        .fault(fault), .fault_cause(fault_cause), .perf_cycles(perf_cycles),
        .perf_instret(perf_instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        if (op == T_SW) return 3'd1;
        if (op == T_BR) return 3'd2;
        if (op == T_LUI || op == T_AUIPC) return 3'd3;
        if (op == T_JAL) return 3'd4;
        return 3'd0;
    endfunction

    // Architectural branch outcome: BEQ/BNE on equality, BLT*/BGE* on the
    // less-than flag (alu_zero = 0 means rs1 < rs2).
    function automatic logic exp_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000:         return z;
            3'b001:         return !z;
            3'b100, 3'b110: return !z;
            3'b101, 3'b111: return z;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(input logic rdy, req, wr, as_, ifw, pcw, rw,
                                input logic [2:0] aop, input logic [1:0] rs, a, b);
        q.push_back({rdy, req, wr, as_, ifw, pcw, rw, aop, rs, a, b});
    endfunction

    function automatic void plan_fetch(input int waits);
        for (int i = 0; i < waits; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 2'd2);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd2, 2'd0, 2'd2);
    endfunction

    function automatic void plan_wb(input logic [1:0] rs);
        add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, rs, 2'd0, 2'd0);
    endfunction

    function automatic void plan_addr();
        add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd2, 2'd1);
    endfunction

    function automatic void plan_data(input int waits, input logic wr);
        for (int i = 0; i < waits; i++) add(1'b0, 1'b1, wr, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
        add(1'b1, 1'b1, wr, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
    endfunction

    // Everything after FETCH: oldPC + imm in DECODE, then the per-class sequence.
    function automatic void plan_body(input logic [6:0] op, input logic [2:0] f3,
                                      input logic z, input int wm);
        add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd1, 2'd1);
        case (op)
            T_R:   begin add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 2'd2, 2'd0); plan_wb(2'd0); end
            T_IMM: begin add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 2'd2, 2'd1); plan_wb(2'd0); end
            T_BR:  add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, exp_taken(f3, z), 1'b0, 3'd3, 2'd0, 2'd2, 2'd0);
            T_JAL: begin add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd1, 2'd2); plan_wb(2'd0); end
            T_AUIPC: plan_wb(2'd0);
            T_LW:  begin plan_addr(); plan_data(wm, 1'b0); plan_wb(2'd1); end
            T_SW:  begin plan_addr(); plan_data(wm, 1'b1); end
            T_LUI: begin plan_addr(); plan_wb(2'd3); end
            T_JALR: begin
                plan_addr();
                add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 2'd2, 2'd1);
                add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd1, 2'd2);
                plan_wb(2'd0);
            end
            default: ;
        endcase
    endfunction

    task automatic run_cycle(input cyc_t e, input logic ef, input logic [1:0] ec, input string tag);
        mem_ready = e.rdy;
        #2;
        check(tag, 64'({mem_req, mem_write, addr_src, instr_flop_wen, pc_wen, reg_write,
                        alu_op, result_src, alu_a_src, alu_b_src, imm_sel, fault, fault_cause}),
                   64'({e.req, e.wr, e.as_, e.ifw, e.pcw, e.rw, e.aop, e.rs, e.a, e.b,
                        exp_imm(opcode), ef, ec}));
        @(posedge clk);
        #1;
        if (!ef) m_cycles++;
    endtask

    task automatic run_queue(input string name, input logic ef, input logic [1:0] ec);
        int i = 0;
        while (q.size() > 0) begin
            run_cycle(q.pop_front(), ef, ec, $sformatf("%s c%0d", name, i));
            i++;
        end
    endtask

    task automatic exec_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic z, input int wf, input int wm);
        opcode = op; funct3 = f3; alu_zero = z;
        q.delete();
        plan_fetch(wf);
        plan_body(op, f3, z, wm);
        run_queue(name, 1'b0, 2'd0);
        m_instret++;
    endtask

    // Trapped: every enable low, fault sticky, stray mem_ready ignored.
    task automatic run_trap(input string name, input logic [1:0] cause);
        q.delete();
        for (int i = 0; i < 4; i++) add(rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
        run_queue(name, 1'b1, cause);
    endtask

    task automatic check_perf(input string name);
`ifdef MULTICYCLE_PERF_CNT_EN
        check({name, " cycles"}, 64'(perf_cycles), 64'(m_cycles));
        check({name, " instret"}, 64'(perf_instret), 64'(m_instret));
`else
        check({name, " cycles"}, 64'(perf_cycles), 64'd0);
        check({name, " instret"}, 64'(perf_instret), 64'd0);
`endif
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, " async"}, 64'({mem_req, mem_write, addr_src, instr_flop_wen, pc_wen, reg_write,
                                     alu_op, result_src, alu_a_src, alu_b_src, imm_sel, fault, fault_cause}), 64'd0);
        check({name, " perf"}, {perf_cycles, perf_instret}, 64'd0);
        @(posedge clk);
        #1;
        check({name, " held"}, 64'({mem_req, pc_wen, reg_write, imm_sel, fault, fault_cause}), 64'd0);
        rst_n = 1'b1;
        m_cycles = 0;
        m_instret = 0;
    endtask

    initial begin
        logic [6:0] legal [9];
        legal = '{T_R, T_IMM, T_BR, T_JAL, T_JALR, T_LW, T_SW, T_LUI, T_AUIPC};
        rst_n = 1'b1; opcode = T_LW; funct3 = 3'd0; alu_zero = 1'b0; mem_ready = 1'b1;
        #1;
        do_reset("por");

        exec_instr("add", T_R, 3'd0, 1'b0, 0, 0);
        check_perf("after add");
        exec_instr("lw3", T_LW, 3'b010, 1'b0, 3, 3);
        exec_instr("bne", T_BR, 3'b001, 1'b0, 0, 0);
        exec_instr("bgeu", T_BR, 3'b111, 1'b1, 1, 0);
        exec_instr("beq", T_BR, 3'b000, 1'b1, 0, 0);
        exec_instr("blt", T_BR, 3'b100, 1'b0, 2, 0);
        exec_instr("br010", T_BR, 3'b010, 1'b1, 0, 0);
        exec_instr("sw", T_SW, 3'b010, 1'b0, 1, 2);
        exec_instr("jal", T_JAL, 3'd0, 1'b0, 0, 0);
        exec_instr("jalr", T_JALR, 3'd0, 1'b0, 2, 0);
        exec_instr("lui", T_LUI, 3'd0, 1'b0, 0, 0);
        exec_instr("auipc", T_AUIPC, 3'd0, 1'b0, 0, 0);
        exec_instr("addi", T_IMM, 3'd0, 1'b0, 3, 0);
        check_perf("directed");

        for (int n = 0; n < 40; n++) begin
            exec_instr($sformatf("rnd%0d", n), legal[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                       rnd_bit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        check_perf("random");

        // Store that never completes: four request cycles, then bus-timeout trap.
        opcode = T_SW; funct3 = 3'b010;
        q.delete();
        plan_fetch(0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd1, 2'd1);
        plan_addr();
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0);
        run_queue("sw_tmo", 1'b0, 2'd0);
        run_trap("sw_trap", 2'd2);
        check_perf("frozen");
        do_reset("rst_after_tmo");

        // Instruction fetch that never completes.
        opcode = T_R;
        q.delete();
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 2'd2);
        run_queue("fetch_tmo", 1'b0, 2'd0);
        run_trap("fetch_trap", 2'd2);
        do_reset("rst_fetch_tmo");

        // Illegal opcode traps out of DECODE.
        opcode = 7'b1111111;
        q.delete();
        plan_fetch(1);
        plan_body(7'b1111111, 3'd0, 1'b0, 0);
        run_queue("illegal", 1'b0, 2'd0);
        run_trap("ill_trap", 2'd1);
        do_reset("rst_illegal");

        // Reset in the middle of a stalled fetch.
        opcode = T_LW;
        q.delete();
        for (int i = 0; i < 2; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 2'd2);
        run_queue("fetch_wait", 1'b0, 2'd0);
        do_reset("rst_mid_fetch");

        exec_instr("jalr_seq", T_JALR, 3'd0, 1'b0, int'($urandom_range(0, 3)), 0);
        for (int n = 0; n < 10; n++) exec_instr($sformatf("add%0d", n), T_R, 3'd0, rnd_bit(), int'($urandom_range(0, 3)), 0);
        check_perf("jalr_plus_10");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
